serial_paralelo: RTL and testbench



---
 rtl/pcie_phy_pkg.sv | 13 +
 rtl/com_aligner.sv | 77 +++++++
 rtl/serial_paralelo.sv | 54 +++++
 tb/tb_serial_paralelo.sv | 161 ++++++++++++++++
 4 files changed

// File: rtl/pcie_phy_pkg.sv
// Symbols and receiver state shared by the PCIe PHY serializer/deserializer pair.
package pcie_phy_pkg;

  localparam logic [7:0] COM = 8'hBC;
  localparam logic [7:0] IDL = 8'h7C;

  typedef enum logic [1:0] {
    HUNT,
    SYNC,
    ACTIVE
  } rx_state_t;

endpackage

// File: rtl/com_aligner.sv
// Byte-alignment tracker: locks onto COM symbols and flags byte boundaries once active.
module com_aligner #(
  parameter logic [7:0]  COM        = pcie_phy_pkg::COM,
  parameter int unsigned SYNC_COUNT = 4
) (
  input  logic       clk_32f,
  input  logic       reset_L,
  input  logic [7:0] nxt,
  output logic       boundary,
  output logic       active
);
  import pcie_phy_pkg::*;

  localparam logic [3:0] SYNC_N = 4'(SYNC_COUNT);

  rx_state_t  state;
  rx_state_t  state_next;
  logic [2:0] bit_cnt;
  logic [2:0] bit_cnt_next;
  logic [3:0] com_cnt;
  logic [3:0] com_cnt_next;
  logic       is_com;

  assign is_com   = (nxt == COM);
  assign boundary = (state == ACTIVE) && (bit_cnt == 3'd7);

  always_ff @(posedge clk_32f or negedge reset_L) begin
    if (!reset_L) begin
      state   <= HUNT;
      bit_cnt <= 3'd0;
      com_cnt <= 4'd0;
      active  <= 1'b0;
    end else begin
      state   <= state_next;
      bit_cnt <= bit_cnt_next;
      com_cnt <= com_cnt_next;
      active  <= (state_next == ACTIVE);
    end
  end

  always_comb begin
    state_next   = state;
    bit_cnt_next = bit_cnt + 3'd1;
    com_cnt_next = com_cnt;
    case (state)
      HUNT: begin
        // Any cycle can be a boundary until a COM pins it down.
        bit_cnt_next = 3'd0;
        if (is_com) begin
          state_next   = SYNC;
          com_cnt_next = 4'd1;
        end
      end
      SYNC: begin
        if (bit_cnt == 3'd7) begin
          if (is_com && ((com_cnt + 4'd1) == SYNC_N)) begin
            state_next   = ACTIVE;
            com_cnt_next = SYNC_N;
          end else if (is_com) begin
            com_cnt_next = com_cnt + 4'd1;
          end else begin
            state_next   = HUNT;
            com_cnt_next = 4'd0;
          end
        end
      end
      ACTIVE: begin
        state_next = ACTIVE;
      end
      default: begin
        state_next   = HUNT;
        com_cnt_next = 4'd0;
      end
    endcase
  end

endmodule

// File: rtl/serial_paralelo.sv
// Serial-to-parallel PCIe lane receiver: MSB-first deserializer with COM-based byte alignment.
module serial_paralelo #(
  parameter logic [7:0]  COM        = pcie_phy_pkg::COM,
  parameter int unsigned SYNC_COUNT = 4
) (
  input  logic       clk_32f,
  input  logic       reset_L,
  input  logic       data_in,
  output logic [7:0] data_out,
  output logic       valid_out,
  output logic       active
);

  logic [7:0] sr;
  logic [7:0] nxt;
  logic       boundary;

  assign nxt = {sr[6:0], data_in};

  com_aligner #(
    .COM        (COM),
    .SYNC_COUNT (SYNC_COUNT)
  ) u_aligner (
    .clk_32f  (clk_32f),
    .reset_L  (reset_L),
    .nxt      (nxt),
    .boundary (boundary),
    .active   (active)
  );

  always_ff @(posedge clk_32f or negedge reset_L) begin
    if (!reset_L) begin
      sr <= 8'h00;
    end else begin
      sr <= nxt;
    end
  end

  // COM bytes in the active stream are idle fill: drop valid but keep the last data byte.
  always_ff @(posedge clk_32f or negedge reset_L) begin
    if (!reset_L) begin
      data_out  <= 8'h00;
      valid_out <= 1'b0;
    end else if (boundary) begin
      if (nxt != COM) begin
        data_out  <= nxt;
        valid_out <= 1'b1;
      end else begin
        valid_out <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_serial_paralelo.sv
// Directed bench for serial_paralelo: alignment, data delivery, idle fill and async reset.
module tb_serial_paralelo;

  logic       clk_32f = 1'b0;
  logic       reset_L = 1'b0;
  logic       data_in = 1'b0;
  logic [7:0] data_out;
  logic       valid_out;
  logic       active;
  int         checks   = 0;
  int         failures = 0;

  serial_paralelo #(
    .COM        (8'hBC),
    .SYNC_COUNT (4)
  ) dut (
    .clk_32f   (clk_32f),
    .reset_L   (reset_L),
    .data_in   (data_in),
    .data_out  (data_out),
    .valid_out (valid_out),
    .active    (active)
  );

  always #5 clk_32f = ~clk_32f;

  task automatic check_eq(input string tag, input logic [7:0] got, input logic [7:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic check_outs(input string tag, input logic [7:0] d, input logic v, input logic a);
    check_eq({tag, "_data"},   data_out,        d);
    check_eq({tag, "_valid"},  8'(valid_out),   8'(v));
    check_eq({tag, "_active"}, 8'(active),      8'(a));
  endtask

  // Drive on the falling edge, return just after the rising edge that sampled it.
  task automatic send_bit(input logic b);
    @(negedge clk_32f);
    data_in = b;
    @(posedge clk_32f);
    #1;
  endtask

  task automatic send_byte(input logic [7:0] b);
    for (int i = 7; i >= 0; i--) send_bit(b[i]);
  endtask

  // Sends a byte while confirming the previous window's outputs hold for its first 7 bits.
  task automatic send_byte_hold(input logic [7:0] b, input logic [7:0] d, input logic v,
                                input string tag);
    for (int i = 7; i >= 0; i--) begin
      send_bit(b[i]);
      if (i != 0) check_outs(tag, d, v, 1'b1);
    end
  endtask

  task automatic do_reset();
    @(negedge clk_32f);
    reset_L = 1'b0;
    data_in = 1'b0;
    repeat (2) @(negedge clk_32f);
    reset_L = 1'b1;
  endtask

  initial begin
    // Reset held while the line toggles
    for (int i = 0; i < 12; i++) begin
      send_bit(i[0]);
      check_outs("rst_hold", 8'h00, 1'b0, 1'b0);
    end
    @(negedge clk_32f);
    reset_L = 1'b1;
    data_in = 1'b0;

    // Aligned sync then data
    for (int k = 0; k < 3; k++) begin
      send_byte(8'hBC);
      check_eq("t2_pre_active", 8'(active), 8'h0);
    end
    send_byte(8'hBC);
    check_outs("t2_sync4", 8'h00, 1'b0, 1'b1);
    send_byte(8'hA5);
    check_outs("t2_a5", 8'hA5, 1'b1, 1'b1);
    send_byte_hold(8'h3C, 8'hA5, 1'b1, "t2_a5_hold");
    check_outs("t2_3c", 8'h3C, 1'b1, 1'b1);
    send_byte_hold(8'hBC, 8'h3C, 1'b1, "t2_3c_hold");
    check_outs("t2_idle", 8'h3C, 1'b0, 1'b1);

    // Misaligned start: junk bits 1,0,1 before the COM run
    do_reset();
    check_outs("t3_reset", 8'h00, 1'b0, 1'b0);
    send_bit(1'b1);
    send_bit(1'b0);
    send_bit(1'b1);
    for (int k = 0; k < 3; k++) send_byte(8'hBC);
    check_eq("t3_bc3_active", 8'(active), 8'h0);
    send_byte(8'hBC);
    check_outs("t3_bc4", 8'h00, 1'b0, 1'b1);
    send_byte(8'hBC);
    check_outs("t3_bc5", 8'h00, 1'b0, 1'b1);
    send_byte(8'h5A);
    check_outs("t3_5a", 8'h5A, 1'b1, 1'b1);

    // Broken sync: 3 COMs, a data byte, then a full run
    do_reset();
    for (int k = 0; k < 3; k++) send_byte(8'hBC);
    check_eq("t4_first3", 8'(active), 8'h0);
    send_byte(8'h00);
    check_outs("t4_break", 8'h00, 1'b0, 1'b0);
    for (int k = 0; k < 3; k++) send_byte(8'hBC);
    check_eq("t4_second3", 8'(active), 8'h0);
    send_byte(8'hBC);
    check_outs("t4_second4", 8'h00, 1'b0, 1'b1);
    send_byte(8'h77);
    check_outs("t4_77", 8'h77, 1'b1, 1'b1);

    // Idle COM between data bytes while active
    do_reset();
    for (int k = 0; k < 4; k++) send_byte(8'hBC);
    send_byte(8'h11);
    check_outs("t5_11", 8'h11, 1'b1, 1'b1);
    send_byte_hold(8'hBC, 8'h11, 1'b1, "t5_11_hold");
    check_outs("t5_idle", 8'h11, 1'b0, 1'b1);
    send_byte_hold(8'h22, 8'h11, 1'b0, "t5_idle_hold");
    check_outs("t5_22", 8'h22, 1'b1, 1'b1);

    // Asynchronous reset in the middle of a data byte
    send_bit(1'b1);
    send_bit(1'b0);
    send_bit(1'b0);
    send_bit(1'b1);
    @(negedge clk_32f);
    reset_L = 1'b0;
    #1;
    check_outs("t6_async", 8'h00, 1'b0, 1'b0);
    @(negedge clk_32f);
    reset_L = 1'b1;
    send_bit(1'b1);
    send_bit(1'b0);
    send_bit(1'b0);
    send_bit(1'b1);
    send_byte(8'h12);
    check_outs("t6_12", 8'h00, 1'b0, 1'b0);
    send_byte(8'h34);
    check_outs("t6_34", 8'h00, 1'b0, 1'b0);
    send_byte(8'hBC);
    send_byte(8'hBC);
    check_outs("t6_bc2", 8'h00, 1'b0, 1'b0);
    send_byte(8'h56);
    check_outs("t6_56", 8'h00, 1'b0, 1'b0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
